// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory-side responder.
//   state_e    : responder FSM states (IDLE, WAIT, RESP)
//   LAT_CNT_W  : width of the read-latency down-counter
package mem_resp_pkg;

    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage : mem_resp_pkg

// File: rtl/mem_resp_array.sv
// Word-addressed register array backing the responder.
// Ports:
//   clk, rst        : clock and asynchronous active-low clear
//   we/waddr/wdata  : synchronous write port
//   raddr/rdata     : combinational read port
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: every word is cleared on reset so a read after reset returns
    // zero; this forces flops rather than a RAM macro, which is intended
    // for a small test-bench storage endpoint.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : mem_resp_array

// File: rtl/mem_ctrl_responder.sv
// Memory-side responder: accepts single-beat read/write requests on a
// valid/ready channel and returns read data after LATENCY cycles on a
// valid/ready response channel. At most one read is outstanding.
// Ports:
//   clk, rst                         : clock, asynchronous active-low reset
//   req_valid/req_ready              : request handshake
//   req_we, req_addr, req_wdata      : request payload (wdata ignored on reads)
//   rsp_valid/rsp_ready, rsp_data    : read response handshake and data
//   busy                             : high whenever the FSM is not IDLE
// All outputs come from registered state only.
module mem_ctrl_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int LATENCY = 2   // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    // WAIT lasts LATENCY-1 cycles: the cycle that sees the count at zero
    // is the last one, so the load value is LATENCY-2.
    localparam logic [LAT_CNT_W-1:0] CNT_LOAD =
        (LATENCY > 1) ? LAT_CNT_W'(LATENCY - 2) : '0;

    state_e               state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [DATA_W-1:0]    rd_word;
    logic                 wr_en;

    // Writes are only taken in IDLE, where req_ready is high.
    assign wr_en = (state_q == IDLE) && req_valid && req_we;

    mem_resp_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (req_addr),
        .wdata (req_wdata),
        .raddr (req_addr),
        .rdata (rd_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // NOTE: every next-state signal gets its hold value first, so no
    // branch can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && !req_we) begin
                    data_d = rd_word;          // array value at the accept edge
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = data_q;               // held at last latched word

endmodule : mem_ctrl_responder

// File: tb/tb_mem_ctrl_responder.sv
// Self-checking bench for mem_ctrl_responder. Two instances are built,
// LATENCY=2 (dut_a) and LATENCY=1 (dut_b); 'sel' routes requests to one of
// them. A per-instance memory model feeds a scoreboard queue of expected
// read words that is drained as responses complete.
module tb_mem_ctrl_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       req_valid, req_we, rsp_ready;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;

    logic       a_req_valid, a_req_ready, a_rsp_valid, a_busy;
    logic       b_req_valid, b_req_ready, b_rsp_valid, b_busy;
    logic [7:0] a_rsp_data, b_rsp_data;

    logic       req_ready_m, rsp_valid_m, busy_m;
    logic [7:0] rsp_data_m;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [2][16];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    assign a_req_valid = req_valid && !sel;
    assign b_req_valid = req_valid && sel;
    assign req_ready_m = sel ? b_req_ready : a_req_ready;
    assign rsp_valid_m = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_data_m  = sel ? b_rsp_data  : a_rsp_data;
    assign busy_m      = sel ? b_busy      : a_busy;

    mem_ctrl_responder #(.DATA_W(8), .ADDR_W(4), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data),
        .busy(a_busy)
    );

    mem_ctrl_responder #(.DATA_W(8), .ADDR_W(4), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data),
        .busy(b_busy)
    );

    function automatic int lat();
        return sel ? 1 : 2;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                model[d][i] = 8'h00;
        exp_q.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic we, input logic [3:0] addr, input logic [7:0] data);
        bit acc = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        for (int n = 0; n < 50; n++) begin
            if (req_ready_m) begin
                acc = 1'b1;
                @(posedge clk);
                break;
            end
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL issue_accept: req_ready=%0b, required 1 within 50 cycles", req_ready_m);
        end else if (we) begin
            model[sel][addr] = data;
        end else begin
            exp_q.push_back(model[sel][addr]);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Waits for the response, holds rsp_ready low for 'hold' cycles, then
    // completes it and checks the handshake back to IDLE.
    task automatic wait_rsp(input int hold);
        int         k = 0;
        logic [7:0] exp;
        rsp_ready = 1'b0;
        while (!rsp_valid_m && k < 40) begin
            @(posedge clk); @(negedge clk); k++;
        end
        checks++;
        if (k + 1 != lat()) begin
            errors++;
            $display("FAIL rsp_latency: rsp_valid seen at edge %0d after accept, required %0d", k + 1, lat());
        end
        if (!rsp_valid_m) return;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: response with empty queue, data=%02h required none", rsp_data_m);
            exp = 8'h00;
        end else begin
            exp = exp_q.pop_front();
        end
        for (int h = 0; h < hold; h++) begin
            checks++;
            if (rsp_valid_m !== 1'b1 || rsp_data_m !== exp || req_ready_m !== 1'b0 || busy_m !== 1'b1) begin
                errors++;
                $display("FAIL rsp_hold: valid=%0b data=%02h req_ready=%0b busy=%0b, required 1 %02h 0 1",
                         rsp_valid_m, rsp_data_m, req_ready_m, busy_m, exp);
            end
            @(posedge clk); @(negedge clk);
        end
        rsp_ready = 1'b1;
        checks++;
        if (rsp_data_m !== exp) begin
            errors++;
            $display("FAIL rsp_data: got %02h, required %02h", rsp_data_m, exp);
        end
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid_m !== 1'b0 || req_ready_m !== 1'b1 || busy_m !== 1'b0 || rsp_data_m !== exp) begin
            errors++;
            $display("FAIL rsp_done: valid=%0b req_ready=%0b busy=%0b data=%02h, required 0 1 0 %02h",
                     rsp_valid_m, req_ready_m, busy_m, rsp_data_m, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        clear_model();
        #12;
        checks++;
        if ({a_req_ready, a_rsp_valid, a_busy, a_rsp_data} !== {3'b100, 8'h00} ||
            {b_req_ready, b_rsp_valid, b_busy, b_rsp_data} !== {3'b100, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs: a=%0b%0b%0b/%02h b=%0b%0b%0b/%02h, required 100/00 for both",
                     a_req_ready, a_rsp_valid, a_busy, a_rsp_data,
                     b_req_ready, b_rsp_valid, b_busy, b_rsp_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        issue(1'b1, 4'd3, 8'hA5);
        issue(1'b0, 4'd3, 8'h00);
        wait_rsp(0);
    endtask

    task automatic test_backpressure();
        issue(1'b0, 4'd3, 8'h00);
        wait_rsp(5);
    endtask

    task automatic test_busy_request();
        issue(1'b0, 4'd3, 8'h00);
        // Write held pending while the read is in flight.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 8'h11;
        wait_rsp(2);
        @(posedge clk);
        model[sel][3] = 8'h11;
        @(negedge clk);
        req_valid = 1'b0;
        issue(1'b0, 4'd3, 8'h00);
        wait_rsp(0);
    endtask

    task automatic test_reset_mid_op();
        issue(1'b0, 4'd3, 8'h00);      // dut_a now in WAIT
        rst = 1'b0;
        #1;
        checks++;
        if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_busy !== 1'b0 || a_rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_wait: valid=%0b req_ready=%0b busy=%0b data=%02h, required 0 1 0 00",
                     a_rsp_valid, a_req_ready, a_busy, a_rsp_data);
        end
        clear_model();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(1'b0, 4'd3, 8'h00);
        wait_rsp(0);
    endtask

    task automatic test_addr_wrap();
        issue(1'b1, 4'd15, 8'hFF);
        issue(1'b1, 4'd0, 8'h01);
        issue(1'b0, 4'd15, 8'h00);
        wait_rsp(1);
        issue(1'b0, 4'd0, 8'h00);
        wait_rsp(0);
        issue(1'b0, 4'd3, 8'h00);
        wait_rsp(0);
    endtask

    task automatic test_lat1_back_to_back();
        int accepts = 0;
        int comps   = 0;
        int last    = -1;
        sel = 1'b1;
        issue(1'b1, 4'd0, 8'h3C);
        issue(1'b1, 4'd1, 8'h5A);
        issue(1'b0, 4'd0, 8'h00);
        wait_rsp(0);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (rsp_valid_m) begin
                comps++;
                checks++;
                if (exp_q.size() == 0 || rsp_data_m !== exp_q[0]) begin
                    errors++;
                    $display("FAIL b2b_data: got %02h, required %02h", rsp_data_m,
                             (exp_q.size() != 0) ? exp_q[0] : 8'hxx);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (req_ready_m) begin
                exp_q.push_back(model[1][req_addr]);
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 2) begin
                        errors++;
                        $display("FAIL b2b_spacing: accept gap %0d cycles, required 2", cyc - last);
                    end
                end
                last = cyc;
                accepts++;
            end
            @(posedge clk); @(negedge clk);
            req_addr = accepts[0] ? 4'd1 : 4'd0;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        checks++;
        if (accepts != 5 || comps != 5 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: accepts=%0d completions=%0d pending=%0d, required 5 5 0",
                     accepts, comps, exp_q.size());
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_backpressure();
        test_busy_request();
        test_reset_mid_op();
        test_addr_wrap();
        test_lat1_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_ctrl_responder
